// File: rtl/pri_cpi_timing_gen_pkg.sv
// Shared types and constants for the PRI/CPI radar timing generator.
package pri_cpi_pkg;

   // Sequencer states; S_GAP is only reachable when PRI_CPI_GAP_EN is defined.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   // Waveform code carried alongside each CPI.
   typedef logic [2:0] wf_t;

   // Shortest PRI the generator will honour, in clock cycles.
   localparam int unsigned MIN_PRI_DEF = 8;

endpackage

// File: rtl/pri_cpi_timing_gen_wrap_counter.sv
// Wrapping up-counter with synchronous load. Exposes the next-state count so
// the parent can register outputs that line up with the counter value.
module wrap_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] cnt_nxt,
   output logic         wrap
);

   logic [W-1:0] cnt;

   // Wrap fires on the cycle the count sits at its terminal value while enabled.
   assign wrap = en && !clr && (cnt == last);

   // Next count: load wins, then wrap to zero, then increment.
   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = load_val;
      else if (wrap)
         cnt_nxt = '0;
      else if (en)
         cnt_nxt = cnt + W'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/pri_cpi_timing_gen.sv
// PRI/CPI timing generator. Latches widths and waveform code at each CPI
// boundary, then emits PRI/CPI strobes, gates and frame markers.
// Optional feature macro: PRI_CPI_GAP_EN inserts CPI_GAP_CYCLES of dead time
// between consecutive CPIs.
module pri_cpi_timing_gen
   import pri_cpi_pkg::*;
#(
   parameter int unsigned PRI_W          = 16,
   parameter int unsigned CPI_W          = 16,
   parameter int unsigned PULSE_LEN      = 4,
   parameter int unsigned MIN_PRI        = MIN_PRI_DEF,
   parameter int unsigned CPI_GAP_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_enable,
   input  logic [PRI_W-1:0] i_PRI_Width,
   input  logic [CPI_W-1:0] i_CPI_Width,
   input  wf_t              i_Waveform_Type,
   output logic             o_PRI_p,
   output logic             o_CPI_p,
   output logic             o_PRI_Internal,
   output logic             o_CPI_Internal,
   output logic             o_First_PRI,
   output logic             o_SRIO_Mem_Sel,
   output wf_t              o_Waveform_Type
);

   state_t           state;
   logic [PRI_W-1:0] pri_len;
   logic [CPI_W-1:0] cpi_len;
   logic [PRI_W-1:0] pri_last;
   logic [CPI_W-1:0] cpi_last;
   logic [PRI_W-1:0] pri_nxt;
   logic [CPI_W-1:0] cpi_nxt;
   logic             pri_wrap;
   logic             cpi_wrap;
   logic             run;
   logic             go_run;

   assign run      = (state == S_RUN);
   assign pri_last = pri_len - PRI_W'(1);
   assign cpi_last = cpi_len - CPI_W'(1);

   // Counters are held at zero outside RUN, so LOAD naturally starts the CPI
   // at pri_cnt = cpi_cnt = 0. cpi_wrap marks the last cycle of a CPI.
   wrap_counter #(.W(PRI_W)) u_pri_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (!run),
      .load_val ('0),
      .en       (run),
      .last     (pri_last),
      .cnt_nxt  (pri_nxt),
      .wrap     (pri_wrap)
   );

   wrap_counter #(.W(CPI_W)) u_cpi_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (!run),
      .load_val ('0),
      .en       (pri_wrap),
      .last     (cpi_last),
      .cnt_nxt  (cpi_nxt),
      .wrap     (cpi_wrap)
   );

   // Next cycle is an active RUN cycle: either leaving LOAD or mid-CPI.
   assign go_run = (state == S_LOAD) || (run && !cpi_wrap);

`ifdef PRI_CPI_GAP_EN
   localparam int unsigned GAP_W = $clog2(CPI_GAP_CYCLES + 1);
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_last;

   assign gap_last = (gap_cnt == GAP_W'(CPI_GAP_CYCLES - 1));

   // Dead-time counter: runs only while in GAP, cleared otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         gap_cnt <= '0;
      else if (state == S_GAP)
         gap_cnt <= gap_cnt + GAP_W'(1);
      else
         gap_cnt <= '0;
   end
`endif

   // Sequencer with registered outputs decoded from the next-state counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         pri_len         <= '0;
         cpi_len         <= '0;
         o_PRI_p         <= 1'b0;
         o_CPI_p         <= 1'b0;
         o_PRI_Internal  <= 1'b0;
         o_CPI_Internal  <= 1'b0;
         o_First_PRI     <= 1'b0;
         o_SRIO_Mem_Sel  <= 1'b0;
         o_Waveform_Type <= '0;
      end else begin
         o_PRI_p        <= go_run && (pri_nxt == '0);
         o_CPI_p        <= go_run && (pri_nxt == '0) && (cpi_nxt == '0);
         o_PRI_Internal <= go_run && (pri_nxt < PRI_W'(PULSE_LEN));
         o_First_PRI    <= go_run && (cpi_nxt == '0);
         o_CPI_Internal <= go_run;
         case (state)
            S_IDLE: begin
               if (i_enable)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               // Shadows are clamped so a zero or tiny width can never stall.
               pri_len         <= (i_PRI_Width < PRI_W'(MIN_PRI)) ? PRI_W'(MIN_PRI) : i_PRI_Width;
               cpi_len         <= (i_CPI_Width == '0) ? CPI_W'(1) : i_CPI_Width;
               o_Waveform_Type <= i_Waveform_Type;
               o_SRIO_Mem_Sel  <= ~o_SRIO_Mem_Sel;
               state           <= S_RUN;
            end
            S_RUN: begin
               if (cpi_wrap) begin
`ifdef PRI_CPI_GAP_EN
                  state <= i_enable ? S_GAP : S_IDLE;
`else
                  state <= i_enable ? S_LOAD : S_IDLE;
`endif
               end
            end
`ifdef PRI_CPI_GAP_EN
            S_GAP: begin
               if (gap_last)
                  state <= i_enable ? S_LOAD : S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pri_cpi_timing_gen.md
Name: pri_cpi_timing_gen

Overview:
Radar timing generator. Produces PRI (pulse repetition interval) and CPI (coherent processing interval) strobes, gates and frame markers from programmed widths. Drives the transmit/receive chain and selects the SRIO ping-pong memory bank. Sits directly downstream of the stimulus/control source that supplies i_PRI_Width, i_CPI_Width and i_Waveform_Type.

Parameters:
PRI_W, 16, width of i_PRI_Width and the PRI counter (clock cycles per PRI)
CPI_W, 16, width of i_CPI_Width and the CPI counter (PRIs per CPI)
PULSE_LEN, 4, cycles o_PRI_Internal is high at the start of each PRI
MIN_PRI, 8, minimum effective PRI width in cycles; must be greater than PULSE_LEN
CPI_GAP_CYCLES, 16, dead time between CPIs (used only with CPI_GAP_EN)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
i_enable  in  1  run request (level)
i_PRI_Width  in  PRI_W  PRI length in clk cycles
i_CPI_Width  in  CPI_W  PRIs per CPI
i_Waveform_Type  in  3  waveform code for the next CPI
o_PRI_p  out  1  1-cycle strobe at every PRI start
o_CPI_p  out  1  1-cycle strobe at every CPI start
o_PRI_Internal  out  1  transmit gate, high for the first PULSE_LEN cycles of each PRI
o_CPI_Internal  out  1  high for the whole active CPI
o_First_PRI  out  1  high for the entire first PRI of each CPI
o_SRIO_Mem_Sel  out  1  ping-pong bank select, toggles at each CPI start
o_Waveform_Type  out  3  waveform code latched for the current CPI

Behaviour:
- Reset: every output is 0; FSM is IDLE; counters and shadow registers are 0. Reset is honoured mid-operation with no drain.
- FSM states: IDLE, LOAD, RUN (plus GAP with CPI_GAP_EN).
- IDLE -> LOAD when i_enable = 1.
- LOAD, one cycle:
  - shadow pri_len = max(i_PRI_Width, MIN_PRI)
  - shadow cpi_len = max(i_CPI_Width, 1)
  - shadow wf = i_Waveform_Type
  - then go to RUN with pri_cnt = 0 and cpi_cnt = 0.
- Latency: i_enable sampled high at edge N -> LOAD in cycle N+1 -> first o_CPI_p and o_PRI_p in cycle N+2.
- RUN:
  - pri_cnt increments each cycle and wraps at pri_len-1. On wrap, cpi_cnt increments.
  - Last cycle of a CPI: pri_cnt = pri_len-1 and cpi_cnt = cpi_len-1.
    - i_enable = 1 -> LOAD (re-latch the shadows). This inserts exactly one LOAD cycle between CPIs, during which all outputs except o_SRIO_Mem_Sel and o_Waveform_Type are 0.
    - i_enable = 0 -> IDLE.
- All outputs are registered and decoded from the next-state counters, so they align with the counter values:
  - o_PRI_p = RUN and pri_cnt == 0
  - o_CPI_p = o_PRI_p and cpi_cnt == 0
  - o_PRI_Internal = RUN and pri_cnt < PULSE_LEN
  - o_First_PRI = RUN and cpi_cnt == 0
  - o_CPI_Internal = RUN
- o_SRIO_Mem_Sel inverts in the same cycle o_CPI_p asserts, so the first CPI after reset shows 1. o_Waveform_Type updates in that same cycle.
- Input changes during RUN have no effect until the next LOAD. Widths and waveform type are never applied mid-CPI.
- i_enable deasserted mid-CPI: the current CPI completes fully, then IDLE. Re-asserting it before CPI end cancels the stop.
- Arithmetic: unsigned compares only; no counter overflow is possible because pri_len <= 2^PRI_W-1.

Optional Feature:
Macro: PRI_CPI_GAP_EN.
- Defined: the RUN -> LOAD transition passes through GAP for CPI_GAP_CYCLES cycles with o_CPI_Internal = 0 and no strobes. i_enable = 0 during GAP -> IDLE after GAP ends. The gap counter is 0 on reset.
- Undefined: no GAP state and no gap counter; transition timing is as in Behaviour.

Decomposition:
- Shared package pri_cpi_pkg holds:
  - FSM state enum (IDLE, LOAD, RUN, GAP)
  - waveform-type typedef (3-bit)
  - MIN_PRI default constant
- One natural sub-module: wrap_counter (parameterised width, load value, wrap strobe out). It is instantiated for the PRI counter and the CPI counter.

Test Plan:
- Reset, then i_enable = 1 with PRI = 20, CPI = 3, wf = 5:
  - o_PRI_p every 20 cycles and o_CPI_p every 61 cycles (60 plus the LOAD cycle)
  - o_First_PRI high for 20 cycles
  - o_PRI_Internal high for 4 cycles per PRI
  - o_Waveform_Type = 5 and o_SRIO_Mem_Sel = 1 in the first CPI, 0 in the second.
- PRI = 0, CPI = 0 -> clamped to 8 cycles per PRI and 1 PRI per CPI; o_PRI_p and o_CPI_p coincide every 9 cycles.
- Change PRI 20 -> 30 and wf 5 -> 2 at PRI 1 of a 3-PRI CPI -> remaining PRIs stay 20 cycles; the next CPI uses 30 and wf 2.
- Drop i_enable at cycle 25 of the CPI (PRI = 20, CPI = 3) -> CPI runs to cycle 59, then IDLE with all strobes and gates 0.
- Assert rstn = 0 mid-PRI -> all outputs 0 asynchronously; after release with i_enable = 1, the first o_CPI_p arrives 2 cycles later.
- With PRI_CPI_GAP_EN, gap = 16, PRI = 10, CPI = 2 -> o_CPI_Internal low for 16 cycles plus 1 LOAD cycle between CPIs; CPI period 37 cycles.
